and_if_checker: RTL and testbench

Synthesizable stimulus-and-check engine for the 4-bit AND interface: drives operand pairs `a`/`b` toward a DUT and samples the returned `y`. It sweeps the full operand space exhaustively, compares each `y` against `a & b`, and reports pass/fail plus a mismatch count. It sits on the driving side of the `and_if` bundle in place of a behavioural testbench, so the AND datapath can be self-checked on silicon or FPGA.

---
 rtl/and_if_checker.sv | 119 +++++++++++
 tb/tb_and_if_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/and_if_checker.sv
// Exhaustive stimulus/check engine for the AND interface: sweeps every {a,b} pair, compares y against a&b.
// Optional first-mismatch capture is built when AND_IF_CHECKER_CAPTURE_EN is defined.
module and_if_checker #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   a_o,
   output logic [WIDTH-1:0]   b_o,
   input  logic [WIDTH-1:0]   y_i,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [7:0]         err_count,
   output logic [2*WIDTH:0]   vec_count,
   output logic [WIDTH-1:0]   first_err_a,
   output logic [WIDTH-1:0]   first_err_b,
   output logic [WIDTH-1:0]   first_err_y
);

   localparam int IW = 2 * WIDTH;
   localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [SW-1:0]   settle;
   logic            mismatch;
   logic            err_sat;
   logic            run_start;

   assign mismatch  = (y_i != (a_o & b_o));
   assign err_sat   = &err_count;
   assign run_start = start && ((state == S_IDLE) || (state == S_DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         settle    <= '0;
         a_o       <= '0;
         b_o       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         vec_count <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  idx       <= '0;
                  err_count <= '0;
                  vec_count <= '0;
                  pass      <= 1'b0;
                  done      <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               {a_o, b_o} <= idx;
               settle     <= SW'(SETTLE_CYCLES);
               state      <= S_WAIT;
            end
            S_WAIT: begin
               settle <= settle - SW'(1);
               if (settle <= SW'(1))
                  state <= S_CHECK;
            end
            S_CHECK: begin
               if (mismatch && !err_sat)
                  err_count <= err_count + 8'd1;
               vec_count <= vec_count + (IW+1)'(1);
               if (&idx) begin
                  // pass must be final on the same edge done rises, so fold in this vector's result
                  pass  <= (err_count == 8'd0) && !mismatch;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx   <= idx + IW'(1);
                  state <= S_DRIVE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef AND_IF_CHECKER_CAPTURE_EN
   // err_count still zero in CHECK marks the first mismatch of the run
   always_ff @(posedge clk) begin
      if (rst || run_start) begin
         first_err_a <= '0;
         first_err_b <= '0;
         first_err_y <= '0;
      end else if ((state == S_CHECK) && mismatch && (err_count == 8'd0)) begin
         first_err_a <= a_o;
         first_err_b <= b_o;
         first_err_y <= y_i;
      end
   end
`else
   assign first_err_a = '0;
   assign first_err_b = '0;
   assign first_err_y = '0;
`endif

endmodule

// File: tb/tb_and_if_checker.sv
// Directed bench for and_if_checker: drives model DUTs (correct, stuck bit, inverted, 2-cycle latency).
module tb_and_if_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic sel = 1'b0;
   int   mode = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   // instance 0: default settle, model selected by mode
   logic [3:0] a_o, b_o, y_i, fa, fb, fy;
   logic       busy, done, pass;
   logic [7:0] err_count;
   logic [8:0] vec_count;
   logic [3:0] l1, l2;

   // instance 1: SETTLE_CYCLES=2 against the latency model
   logic [3:0] a_o2, b_o2, y_i2, fa2, fb2, fy2;
   logic       busy2, done2, pass2;
   logic [7:0] err_count2;
   logic [8:0] vec_count2;
   logic [3:0] m1, m2;

   always_ff @(posedge clk) begin
      l1 <= a_o & b_o;
      l2 <= l1;
      m1 <= a_o2 & b_o2;
      m2 <= m1;
   end

   always_comb begin
      case (mode)
         1:       y_i = (a_o & b_o) | 4'b0001;
         2:       y_i = ~(a_o & b_o);
         3:       y_i = l2;
         default: y_i = a_o & b_o;
      endcase
   end
   assign y_i2 = m2;

   and_if_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .start(start & ~sel),
      .a_o(a_o), .b_o(b_o), .y_i(y_i),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .vec_count(vec_count),
      .first_err_a(fa), .first_err_b(fb), .first_err_y(fy)
   );

   and_if_checker #(.WIDTH(4), .SETTLE_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start & sel),
      .a_o(a_o2), .b_o(b_o2), .y_i(y_i2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err_count2), .vec_count(vec_count2),
      .first_err_a(fa2), .first_err_b(fb2), .first_err_y(fy2)
   );

   wire       s_busy = sel ? busy2 : busy;
   wire       s_done = sel ? done2 : done;
   wire       s_pass = sel ? pass2 : pass;
   wire [7:0] s_err  = sel ? err_count2 : err_count;
   wire [8:0] s_vec  = sel ? vec_count2 : vec_count;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a"}, a_o, 0);
      chk({tag, "_b"}, b_o, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_err"}, err_count, 0);
      chk({tag, "_vec"}, vec_count, 0);
      chk({tag, "_fea"}, fa, 0);
      chk({tag, "_feb"}, fb, 0);
      chk({tag, "_fey"}, fy, 0);
   endtask

   // exp_err < 0 skips the count check; poke > 0 pulses start that many edges into the run
   task automatic do_run(input string tag, input int exp_edges, input bit exp_pass,
                         input int exp_err, input int poke);
      int edges;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk({tag, "_busy_start"}, s_busy, 1);
      chk({tag, "_done_start"}, s_done, 0);
      chk({tag, "_err_start"}, s_err, 0);
      chk({tag, "_vec_start"}, s_vec, 0);
      edges = 0;
      while (!s_done && edges < 3000) begin
         @(posedge clk);
         #1 edges++;
         start = (edges == poke);
      end
      start = 1'b0;
      chk({tag, "_edges"}, edges, exp_edges);
      chk({tag, "_busy_end"}, s_busy, 0);
      chk({tag, "_pass"}, s_pass, exp_pass);
      chk({tag, "_vec"}, s_vec, 256);
      if (exp_err >= 0)
         chk({tag, "_err"}, s_err, exp_err);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 chk_zero("reset");
      rst = 1'b0;

      mode = 0;
      do_run("good", 768, 1'b1, 0, 0);
      chk("good_a_hold", a_o, 4'hF);
      chk("good_b_hold", b_o, 4'hF);
      chk("good_fey", fy, 0);

      mode = 1;
      do_run("stuck", 768, 1'b0, 192, 0);
      chk("stuck_fea", fa, 0);
      chk("stuck_feb", fb, 0);
`ifdef AND_IF_CHECKER_CAPTURE_EN
      chk("stuck_fey", fy, 4'b0001);
`else
      chk("stuck_fey", fy, 4'b0000);
`endif

      mode = 2;
      do_run("inv", 768, 1'b0, 255, 0);
`ifdef AND_IF_CHECKER_CAPTURE_EN
      chk("inv_fey", fy, 4'hF);
`else
      chk("inv_fey", fy, 4'h0);
`endif
      // start asserted while already DONE: restart clears counters on that edge
      do_run("restart", 768, 1'b0, 255, 0);

      // reset partway through a run
      mode = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("mid_vec", vec_count, 1);
      chk("mid_err", err_count, 0);
      chk("mid_busy", busy, 1);
      chk("mid_a", a_o, 0);
      chk("mid_b", b_o, 0);
      repeat (96) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk_zero("midrst");
      do_run("after_rst", 768, 1'b1, 0, 50);

      mode = 3;
      do_run("lat_s1", 768, 1'b0, -1, 0);

      sel = 1'b1;
      do_run("lat_s2", 1024, 1'b1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
